// File: rtl/seq_pkg.sv
// Package for seq_word_serializer.
// Holds the serializer state encoding and the default word width.
package seq_pkg;

    typedef enum logic [1:0] {
        SER_IDLE   = 2'd0,
        SER_SHIFT  = 2'd1,
        SER_PARITY = 2'd2
    } ser_state_t;

    localparam int SER_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/seq_word_serializer.sv
// seq_word_serializer
// Parallel-to-serial word serializer. It accepts words over a valid/ready
// handshake and emits them one bit per clock on ser_out, with ser_valid
// marking the frame bits. Storage is one shift register plus a one-word
// holding register, so back-to-back words stream without a gap.
//
// Optional feature: define SER_PARITY_EN to append one even-parity bit
// (XOR of the word) after the data bits, making a frame WIDTH+1 bits.
//
// Parameters:
//   WIDTH      data word width in bits (2..32)
//   MSB_FIRST  1 = MSB first, 0 = LSB first
// Ports:
//   clk        clock, all state updates on its rising edge
//   reset      asynchronous active-high reset
//   in_valid   upstream word offered
//   in_data    upstream word, captured on handshake
//   in_ready   a word can be accepted this cycle (holding register empty)
//   ser_out    registered serial bit, 0 whenever ser_valid is 0
//   ser_valid  registered, ser_out carries a frame bit
//   busy       shifter active or holding register full
//
// state      | meaning
// -----------+--------------------------------------------------------
// SER_IDLE   | no frame in flight; a handshake loads the shifter
// SER_SHIFT  | data bits on ser_out; bit counter tracks the current bit
// SER_PARITY | parity bit on ser_out (only with SER_PARITY_EN)
module seq_word_serializer
    import seq_pkg::*;
#(
    parameter int WIDTH     = SER_WIDTH_DEFAULT,
    parameter bit MSB_FIRST = 1'b1
) (
    input  bit               clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    ser_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             ser_out_d, ser_valid_d;
`ifdef SER_PARITY_EN
    logic             par_q, par_d;
`endif

    logic             hs;
    logic             frame_end;
    logic             do_load;
    logic [WIDTH-1:0] load_word;

    // Ready depends only on the holding register; it is also forced low
    // while reset is asserted so nothing is offered into a clearing block.
    assign in_ready = ~hold_full_q & ~reset;
    assign hs       = in_valid & in_ready;
    assign busy     = (state_q != SER_IDLE) || hold_full_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= SER_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            ser_out     <= 1'b0;
            ser_valid   <= 1'b0;
`ifdef SER_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            ser_out     <= ser_out_d;
            ser_valid   <= ser_valid_d;
`ifdef SER_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        ser_out_d   = 1'b0;
        ser_valid_d = 1'b0;
        frame_end   = 1'b0;
        do_load     = 1'b0;
        load_word   = in_data;
`ifdef SER_PARITY_EN
        par_d       = par_q;
`endif

        case (state_q)
            SER_IDLE: begin
                if (hs) begin
                    do_load = 1'b1;
                end
            end
            SER_SHIFT: begin
                if (cnt_q == CNT_LAST) begin
`ifdef SER_PARITY_EN
                    state_d     = SER_PARITY;
                    ser_out_d   = par_q;
                    ser_valid_d = 1'b1;
`else
                    frame_end   = 1'b1;
`endif
                end else begin
                    // The first bit was emitted at load time, so the
                    // shifter always holds the next bit at its output end.
                    cnt_d       = cnt_q + CW'(1);
                    ser_valid_d = 1'b1;
                    if (MSB_FIRST) begin
                        ser_out_d = shift_q[WIDTH-1];
                        shift_d   = shift_q << 1;
                    end else begin
                        ser_out_d = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end
            end
`ifdef SER_PARITY_EN
            SER_PARITY: begin
                frame_end = 1'b1;
            end
`endif
            default: begin
                state_d = SER_IDLE;
            end
        endcase

        if (frame_end) begin
            // A held word cannot coincide with a handshake: in_ready is low.
            if (hold_full_q) begin
                do_load     = 1'b1;
                load_word   = hold_q;
                hold_full_d = 1'b0;
            end else if (hs) begin
                do_load = 1'b1;
            end else begin
                state_d = SER_IDLE;
            end
        end else if (hs && (state_q != SER_IDLE)) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
        end

        if (do_load) begin
            state_d     = SER_SHIFT;
            cnt_d       = '0;
            ser_valid_d = 1'b1;
`ifdef SER_PARITY_EN
            par_d       = ^load_word;
`endif
            if (MSB_FIRST) begin
                ser_out_d = load_word[WIDTH-1];
                shift_d   = load_word << 1;
            end else begin
                ser_out_d = load_word[0];
                shift_d   = load_word >> 1;
            end
        end
    end

endmodule

// File: tb/tb_seq_word_serializer.sv
// Testbench for seq_word_serializer (WIDTH=8). Two instances share the
// inputs: one MSB-first, one LSB-first. A queue-based model of the expected
// bit stream checks every cycle; a constant table and hand sequences cover
// the documented examples. Honours SER_PARITY_EN for the frame length.
module tb_seq_word_serializer;

`ifdef SER_PARITY_EN
    localparam int FRAME = 9;
`else
    localparam int FRAME = 8;
`endif

    bit         clk;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       m_ready, m_out, m_valid, m_busy;
    logic       l_ready, l_out, l_valid, l_busy;

    int total = 0;
    int bad   = 0;

    bit qm[$];
    bit ql[$];

    typedef struct {
        logic [7:0] word;
        bit         msb;
        logic [7:0] seq;   // emission order, leftmost bit first
        bit         par;
    } vec_t;

    vec_t tbl[6];

    seq_word_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(m_ready), .ser_out(m_out), .ser_valid(m_valid), .busy(m_busy)
    );

    seq_word_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(l_ready), .ser_out(l_out), .ser_valid(l_valid), .busy(l_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input logic got, input logic exp, input string nm);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic chk_int(input int got, input int exp, input string nm);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
        end
    endtask

    // Append a whole frame for an accepted word to the expected stream.
    task automatic push_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            qm.push_back(w[7-i]);
            ql.push_back(w[i]);
        end
`ifdef SER_PARITY_EN
        qm.push_back(^w);
        ql.push_back(^w);
`endif
    endtask

    task automatic check_one(input int which, input logic sv, input logic so,
                             input logic rdy, input logic bz);
        bit exp_v, exp_b;
        int left;
        string tag;
        exp_b = 1'b0;
        if (which == 0) begin
            tag   = "msb";
            exp_v = (qm.size() != 0);
            if (exp_v) exp_b = qm.pop_front();
            left  = qm.size();
        end else begin
            tag   = "lsb";
            exp_v = (ql.size() != 0);
            if (exp_v) exp_b = ql.pop_front();
            left  = ql.size();
        end
        chk(sv, exp_v, {tag, "_ser_valid"});
        chk(so, exp_b, {tag, "_ser_out"});
        chk(bz, exp_v, {tag, "_busy"});
        chk(rdy, left < FRAME, {tag, "_in_ready"});
    endtask

    // One clock: drive inputs, take the edge, check both instances.
    task automatic step(input logic v, input logic [7:0] d);
        logic hs;
        in_valid = v;
        in_data  = d;
        hs = v && m_ready;
        @(posedge clk);
        if (hs) push_word(d);
        @(negedge clk);
        check_one(0, m_valid, m_out, m_ready, m_busy);
        check_one(1, l_valid, l_out, l_ready, l_busy);
    endtask

    initial begin
        logic [7:0] got;
        logic       pbit;
        int         cnt;

        tbl[0] = '{word: 8'h93, msb: 1'b1, seq: 8'b10010011, par: 1'b0};
        tbl[1] = '{word: 8'h01, msb: 1'b0, seq: 8'b10000000, par: 1'b1};
        tbl[2] = '{word: 8'h07, msb: 1'b1, seq: 8'b00000111, par: 1'b1};
        tbl[3] = '{word: 8'hA5, msb: 1'b0, seq: 8'b10100101, par: 1'b0};
        tbl[4] = '{word: 8'h3C, msb: 1'b1, seq: 8'b00111100, par: 1'b0};
        tbl[5] = '{word: 8'hC1, msb: 1'b0, seq: 8'b10000011, par: 1'b1};

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk(m_ready, 1'b0, "rst_in_ready");
        chk(m_valid, 1'b0, "rst_ser_valid");
        chk(m_out,   1'b0, "rst_ser_out");
        chk(m_busy,  1'b0, "rst_busy");
        chk(l_ready, 1'b0, "rst_lsb_in_ready");
        reset = 1'b0;
        #1;
        chk(m_ready, 1'b1, "post_rst_in_ready");
        chk(l_ready, 1'b1, "post_rst_lsb_in_ready");

        // Table: single words from idle, exact bit sequence and frame length.
        for (int t = 0; t < 6; t++) begin
            got = '0;
            step(1'b1, tbl[t].word);
            got[7] = tbl[t].msb ? m_out : l_out;
            for (int i = 1; i < 8; i++) begin
                step(1'b0, 8'h00);
                got[7-i] = tbl[t].msb ? m_out : l_out;
            end
            chk_int(int'(got), int'(tbl[t].seq), $sformatf("tbl%0d_bits", t));
`ifdef SER_PARITY_EN
            step(1'b0, 8'h00);
            pbit = tbl[t].msb ? m_out : l_out;
            chk(pbit, tbl[t].par, $sformatf("tbl%0d_parity", t));
`else
            pbit = tbl[t].par;
`endif
            step(1'b0, 8'h00);
            chk(tbl[t].msb ? m_valid : l_valid, 1'b0, $sformatf("tbl%0d_frame_end", t));
        end

        // Back-to-back words: second goes to hold, stream stays contiguous.
        step(1'b1, 8'h99);
        step(1'b1, 8'h99);
        chk(m_ready, 1'b0, "b2b_hold_full_ready");
        cnt = 2;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 8'h00);
            if (!m_valid) break;
            cnt++;
        end
        chk_int(cnt, 2 * FRAME, "b2b_contiguous_bits");

        // Handshake exactly on the final-bit edge with hold empty.
        step(1'b1, 8'h5A);
        for (int i = 1; i < FRAME; i++) step(1'b0, 8'h00);
        step(1'b1, 8'hC3);
        chk(m_valid, 1'b1, "final_edge_no_gap");
        chk(m_out,   1'b1, "final_edge_first_bit");
        for (int i = 0; i < FRAME + 2; i++) step(1'b0, 8'h00);

        // Reset mid-frame with a held word: everything is discarded.
        step(1'b1, 8'hF0);
        step(1'b1, 8'h0F);
        step(1'b0, 8'h00);
        #1;
        reset = 1'b1;
        #1;
        chk(m_valid, 1'b0, "midrst_ser_valid");
        chk(m_out,   1'b0, "midrst_ser_out");
        chk(m_busy,  1'b0, "midrst_busy");
        chk(m_ready, 1'b0, "midrst_in_ready");
        qm.delete();
        ql.delete();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk(m_ready, 1'b1, "midrst_release_ready");
        for (int i = 0; i < 2 * FRAME + 2; i++) step(1'b0, 8'h00);

        // Random traffic against the stream model.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom));
        end
        for (int i = 0; i < 2 * FRAME + 2; i++) step(1'b0, 8'h00);
        chk_int(qm.size(), 0, "drain_msb_queue");
        chk_int(ql.size(), 0, "drain_lsb_queue");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_word_serializer.md
SEQ_WORD_SERIALIZER -- requirements
Module: seq_word_serializer

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1, bit order: 1 = MSB first, 0 = LSB first.
REQ-003 clk  input  1  single clock; port type bit; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  upstream word offered.
REQ-006 in_data  input  WIDTH  upstream word; sampled only on handshake.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 ser_out  output  1  serial bit stream, one bit per clock; drives the sequence detector's din.
REQ-009 ser_valid  output  1  ser_out carries a frame bit this cycle.
REQ-010 busy  output  1  shifter active or holding register full.

Function
REQ-011 Handshake SHALL occur at a posedge where in_valid && in_ready; in_data is captured on that edge.
REQ-012 in_ready SHALL equal ~hold_full, with no combinational path from in_valid or the shifter state.
REQ-013 Storage SHALL be one shift register plus a one-word holding register.
REQ-014 FSM states SHALL be SER_IDLE, SER_SHIFT and SER_PARITY; SER_PARITY is reachable only with SER_PARITY_EN.
REQ-015 SER_IDLE: on handshake, load the shifter directly and go to SER_SHIFT; first bit appears on ser_out in the cycle after the handshake edge (latency 1).
REQ-016 SER_SHIFT: emit one bit per cycle, ordered per MSB_FIRST; a bit counter counts 0..WIDTH-1.
REQ-017 A handshake during SER_SHIFT or SER_PARITY SHALL write the holding register.
REQ-018 At the edge ending the final frame bit, with the holding register full: move hold into the shifter, clear hold_full, stay in SER_SHIFT; the stream has no gap.
REQ-019 At that same edge, with hold empty and a simultaneous handshake: load in_data directly into the shifter, stay in SER_SHIFT; no gap.
REQ-020 At that same edge, with hold empty and no handshake: go to SER_IDLE; ser_valid = 0 next cycle.
REQ-021 When ser_valid = 0, ser_out SHALL be 0.
REQ-022 ser_out and ser_valid SHALL be registered outputs.
REQ-023 busy SHALL be 1 iff state != SER_IDLE or hold_full = 1.

Reset
REQ-024 Reset SHALL asynchronously force state = SER_IDLE, bit counter = 0, hold_full = 0, shifter = 0.
REQ-025 Reset SHALL force ser_out = 0, ser_valid = 0 and busy = 0.
REQ-026 in_ready SHALL be 0 while reset is asserted and 1 on the first cycle after deassertion.
REQ-027 Reset mid-frame SHALL discard the partial frame and any held word; no bits of either are emitted afterwards.

Configuration
REQ-028 Macro SER_PARITY_EN defined: after WIDTH data bits, one SER_PARITY cycle SHALL emit even parity (XOR of the word) with ser_valid = 1; frame = WIDTH+1 bits.
REQ-029 SER_PARITY_EN undefined: frame = WIDTH bits; SER_PARITY logic SHALL not be compiled.
REQ-030 REQ-018 to REQ-020 SHALL apply at the final bit of the frame in either configuration.

Structure
REQ-031 Package seq_pkg SHALL hold typedef enum logic [1:0] ser_state_t {SER_IDLE, SER_SHIFT, SER_PARITY}.
REQ-032 Package seq_pkg SHALL hold constant SER_WIDTH_DEFAULT = 8.
REQ-033 Single module, no sub-module; the holding register is inline.

Verification
REQ-034 Word 8'h93, MSB_FIRST=1 -> ser_out 1,0,0,1,0,0,1,1 on 8 consecutive cycles starting one cycle after handshake; ser_valid high exactly 8 cycles; the detector asserts its output once.
REQ-035 Words 8'h99 then 8'h99 offered back-to-back -> 16 contiguous valid bits with no gap; in_ready low while hold is full.
REQ-036 MSB_FIRST=0, word 8'h01 -> ser_out 1,0,0,0,0,0,0,0.
REQ-037 Reset asserted after 3 bits of 8'hF0 with 8'h0F held -> ser_valid = 0 immediately, busy = 0, no further bits, in_ready = 1 after release.
REQ-038 With SER_PARITY_EN, word 8'h93 -> 8 data bits then parity bit 0; word 8'h07 -> parity bit 1; ser_valid high 9 cycles.
REQ-039 Handshake on the final-bit edge with hold empty -> next word starts on the following cycle with no gap.
